// File: rtl/sbox_lane_array.sv
// sbox_lane_array: stallable multi-lane AES forward/inverse S-box with valid/ready and a sideband tag.
module sbox_lane_array #(
  parameter int LANES = 4,
  parameter int PIPE  = 2,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_inv
);
  localparam int W = 8 * LANES;
  logic [PIPE-1:0] vld_q, vld_d, inv_q, inv_d, ld, take;
  logic [W-1:0] dat_q [PIPE];
  logic [W-1:0] dat_d [PIPE];
  logic [TAG_W-1:0] tag_q [PIPE];
  logic [TAG_W-1:0] tag_d [PIPE];
  logic [W-1:0] lut;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [7:0] fwd_sb(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sb(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction
  always_comb begin
    lut = '0;
    for (int i = 0; i < LANES; i++)
      lut[8*i+:8] = in_inv ? inv_sb(in_data[8*i+:8]) : fwd_sb(in_data[8*i+:8]);
  end
  // a stage can load if any stage from it to the output is empty, or the output drains
  always_comb begin
    logic full;
    ld = '0;
    take = '0;
    for (int k = 0; k < PIPE; k++) begin
      full = 1'b1;
      for (int j = k; j < PIPE; j++) full = full & vld_q[j];
      ld[k] = out_ready | !full;
    end
    take[0] = ld[0] & in_valid;
    vld_d[0] = ld[0] ? in_valid : vld_q[0];
    dat_d[0] = take[0] ? lut : dat_q[0];
    tag_d[0] = take[0] ? in_tag : tag_q[0];
    inv_d[0] = take[0] ? in_inv : inv_q[0];
    for (int k = 1; k < PIPE; k++) begin
      take[k] = ld[k] & vld_q[k-1];
      vld_d[k] = ld[k] ? vld_q[k-1] : vld_q[k];
      dat_d[k] = take[k] ? dat_q[k-1] : dat_q[k];
      tag_d[k] = take[k] ? tag_q[k-1] : tag_q[k];
      inv_d[k] = take[k] ? inv_q[k-1] : inv_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      inv_q <= '0;
      for (int k = 0; k < PIPE; k++) begin
        dat_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      inv_q <= inv_d;
      dat_q <= dat_d;
      tag_q <= tag_d;
    end
  end
  assign in_ready  = ld[0];
  assign out_valid = vld_q[PIPE-1];
  assign out_data  = dat_q[PIPE-1];
  assign out_tag   = tag_q[PIPE-1];
  assign out_inv   = inv_q[PIPE-1];
endmodule

// File: tb/tb_sbox_lane_array.sv
// tb_sbox_lane_array: directed checks of lookup, streaming, backpressure and reset for LANES=4, PIPE=2.
module tb_sbox_lane_array;
  localparam int LANES = 4;
  localparam int PIPE  = 2;
  localparam int TAG_W = 4;
  localparam int W     = 8 * LANES;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_inv;
  logic [W-1:0] in_data = '0, out_data;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic [W-1:0] fw [64];
  int n_chk = 0, n_fail = 0;
  localparam logic [W-1:0] VA = 32'h19A0_9AE9, SA = 32'hD4E0_B81E;
  localparam logic [W-1:0] VB = 32'h3DF4_C6F8, SB = 32'h27BF_B441;
  localparam logic [W-1:0] VC = 32'hE3E2_8D48, SC = 32'h1198_5D52;
  localparam logic [W-1:0] VD = 32'hBE2B_2A08, SD = 32'hAEF1_E530;
  sbox_lane_array #(.LANES(LANES), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_inv(out_inv)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  function automatic logic [W-1:0] word(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction
  task automatic one(input logic [W-1:0] d, input logic inv, input logic [3:0] t, input logic [W-1:0] exp_d);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = d; in_inv = inv; in_tag = t;
    #1 chk("one_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("one_latency_gap", out_valid, 1'b0);
    @(negedge clk);
    chk("one_valid", out_valid, 1'b1);
    chk("one_data", out_data, exp_d);
    chk("one_tag", out_tag, t);
    chk("one_inv", out_inv, inv);
  endtask
  // mode 0: all forward, capturing results; mode 1/2: alternating modes, round trip against known bytes
  task automatic stream(input int mode);
    int i;
    logic iv;
    for (int c = 0; c < 66; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c >= 2) begin
        i = c - 2;
        iv = (mode == 0) ? 1'b0 : ((mode == 1) ? !i[0] : i[0]);
        chk("strm_valid", out_valid, 1'b1);
        chk("strm_tag", out_tag, i[3:0]);
        chk("strm_inv", out_inv, iv);
        if (mode == 0) fw[i] = out_data;
        else chk("strm_data", out_data, iv ? word(i) : fw[i]);
        if (mode == 0 && i == 0) chk("strm_fwd_first", out_data, 32'h7B77_7C63);
        if (mode == 0 && i == 63) chk("strm_fwd_last", out_data, 32'h16BB_54B0);
      end
      if (c < 64) begin
        iv = (mode == 0) ? 1'b0 : ((mode == 1) ? !c[0] : c[0]);
        in_valid = 1'b1; in_tag = c[3:0]; in_inv = iv;
        in_data = iv ? fw[c] : word(c);
        #1 chk("strm_in_ready", in_ready, 1'b1);
      end else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("strm_drained", out_valid, 1'b0);
  endtask
  initial begin
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    chk("rst_out_inv", out_inv, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    one(32'hFF53_0100, 1'b0, 4'd3, 32'h16ED_7C63);
    one(32'h16ED_7C63, 1'b1, 4'd4, 32'hFF53_0100);
    one(VA, 1'b0, 4'd5, SA);
    one(VB, 1'b0, 4'd6, SB);
    one(SC, 1'b1, 4'd7, VC);
    one(SD, 1'b1, 4'd8, VD);
    stream(0);
    stream(1);
    stream(2);
    // backpressure: three attempts while stalled, only two fit
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = VA; in_tag = 4'd10;
    #1 chk("bp_rdy_a", in_ready, 1'b1);
    @(negedge clk);
    chk("bp_gap", out_valid, 1'b0);
    in_data = VB; in_tag = 4'd11;
    #1 chk("bp_rdy_b", in_ready, 1'b1);
    @(negedge clk);
    chk("bp_valid_a", out_valid, 1'b1);
    chk("bp_data_a", out_data, SA);
    in_data = VC; in_tag = 4'd12;
    #1 chk("bp_full_rdy", in_ready, 1'b0);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_data", out_data, SA);
      chk("bp_hold_tag", out_tag, 4'd10);
      chk("bp_hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1 chk("bp_full_drain_rdy", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_data_b", out_data, SB);
    chk("bp_tag_b", out_tag, 4'd11);
    @(negedge clk);
    chk("bp_valid_c", out_valid, 1'b1);
    chk("bp_data_c", out_data, SC);
    chk("bp_tag_c", out_tag, 4'd12);
    @(negedge clk);
    chk("bp_empty", out_valid, 1'b0);
    // reset with two transactions in flight
    out_ready = 1'b0; in_valid = 1'b1; in_data = VA; in_tag = 4'd1;
    @(negedge clk);
    in_data = VB; in_tag = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rr_inflight", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_out_valid", out_valid, 1'b0);
    chk("rr_out_data", out_data, 32'h0);
    chk("rr_out_tag", out_tag, 4'h0);
    chk("rr_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = VD; in_tag = 4'd5; in_inv = 1'b0;
    #1 chk("rr_first_rdy", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rr_no_stale", out_valid, 1'b0);
    @(negedge clk);
    chk("rr_valid", out_valid, 1'b1);
    chk("rr_data", out_data, SD);
    chk("rr_tag", out_tag, 4'd5);
    @(negedge clk);
    chk("rr_empty", out_valid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
